csr_file: RTL
=============

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: csr_ID  in  4  read index from decode (0 mstatus, 1 mtvec, 2 mie, 3 mip, 4 mepc, 5 instreth, 6 instret, 7 cycleh, 8 cycle, 15 invalid).
REQ-004 SHALL have ports: csr_rdata  out  32  combinational read data for csr_ID.
REQ-005 SHALL have ports: isCSR_WB  in  1  CSR instruction retiring in WB; csr_WB  in  4  its index; funct3_WB  in  3  op; wdata_WB  in  32  operand (rs1 or zero-extended uimm, selected upstream).
REQ-006 SHALL have ports: isMRET_WB  in  1; isWFI_WB  in  1; isinstruct_WB  in  1  retire pulse.
REQ-007 SHALL have ports: resume_pc  in  32  PC saved to mepc on trap; ext_irq  in  1  level; timer_irq  in  1  level.
REQ-008 SHALL have ports: redirect  out  1  one-cycle pulse; redirect_pc  out  32; WFI_interrupt  out  1  pipeline hold while waiting.

Function
REQ-009 Write ops, keyed on funct3_WB[1:0]: 01 write, 10 set (old|wdata), 11 clear (old&~wdata); 00 SHALL cause no write.
REQ-010 Writable fields only: mstatus[3] MIE, [7] MPIE; mtvec[31:2] (mtvec[1:0] read 0); mie[11] MEIE, [7] MTIE; mepc[31:2] (mepc[1:0] read 0); all other bits SHALL read 0, except mstatus[12:11] MPP, which SHALL read 2'b11.
REQ-011 mip[11] SHALL equal ext_irq and mip[7] SHALL equal timer_irq; writes to mip, counters or index 15 SHALL be ignored; index 15 SHALL read 0.
REQ-012 cycle (64-bit) SHALL increment every cycle after reset; instret (64-bit) SHALL increment when isinstruct_WB=1; both SHALL wrap at 2^64-1 -> 0; cycleh/instreth SHALL read bits 63:32.
REQ-013 Read bypass: if isCSR_WB and csr_WB==csr_ID and the op writes, csr_rdata SHALL return the post-write value.
REQ-014 pending = (mie & mip) != 0; trap condition = pending & MIE & state RUN & !isMRET_WB.
REQ-015 FSM states: RUN, WFI, TRAP.
REQ-016 RUN -> WFI on isWFI_WB when !pending; WFI_interrupt SHALL be 1 only in WFI.
REQ-017 WFI -> RUN when pending & !MIE (no redirect); WFI -> TRAP when pending & MIE.
REQ-018 RUN -> TRAP on trap condition.
REQ-019 Entering TRAP SHALL set mepc<=resume_pc, MPIE<=MIE, MIE<=0; in TRAP, redirect=1 and redirect_pc=mtvec for exactly that one cycle; TRAP -> RUN unconditionally.
REQ-020 MRET in RUN SHALL set MIE<=MPIE, MPIE<=1, pulse redirect with redirect_pc=mepc in the same cycle (combinational).
REQ-021 A simultaneous CSR write and trap entry SHALL apply the CSR write first, then trap updates to MIE/MPIE/mepc (trap updates win).
REQ-022 MRET and a pending interrupt in the same cycle: MRET SHALL be taken; the trap SHALL be evaluated the next cycle.
REQ-023 Every output SHALL be glitch-free relative to registered state except csr_rdata and the MRET redirect.

Reset
REQ-024 On rst: all CSRs and counters SHALL be 0 (MPP still reads 11), state RUN, redirect=0, WFI_interrupt=0.
REQ-025 Reset asserted mid-WFI or mid-TRAP SHALL abort to RUN immediately with no redirect.

Configuration
REQ-026 Macro CSR_TIMER_IRQ_EN defined: MTIE writable and mip[7]=timer_irq.
REQ-027 Macro CSR_TIMER_IRQ_EN undefined: MTIE and mip[7] SHALL read 0, timer_irq SHALL be ignored (port retained).

Verification
REQ-028 CSRRW mtvec wdata=0x0000_0103 -> mtvec reads 0x0000_0100; CSRRS mstatus 0x8 -> MIE=1; same-cycle ID read returns the new value.
REQ-029 MIE=1, MEIE=1, resume_pc=0x200, ext_irq=1 -> redirect to mtvec next cycle, mepc=0x200, MIE=0, MPIE=1; then MRET -> redirect_pc=0x200, MIE=1.
REQ-030 WFI with MIE=0, MEIE=1; ext_irq rises after 10 cycles -> WFI_interrupt high for 10 cycles, then RUN, no redirect.
REQ-031 Preload instret=0xFFFF_FFFF via 2^32-1 retire pulses (or force) -> one more pulse gives instreth=1, instret=0; a CSRRW to cycle leaves cycle unchanged.
REQ-032 Timer IRQ with MTIE=1, MIE=1: trap taken only when CSR_TIMER_IRQ_EN is defined; reset asserted during TRAP -> redirect=0 and all CSRs 0.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with cycle/instret counters and RUN/WFI/TRAP control; define CSR_TIMER_IRQ_EN to enable the timer interrupt
module csr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  csr_ID,
    output logic [31:0] csr_rdata,
    input  logic        isCSR_WB,
    input  logic [3:0]  csr_WB,
    input  logic [2:0]  funct3_WB,
    input  logic [31:0] wdata_WB,
    input  logic        isMRET_WB,
    input  logic        isWFI_WB,
    input  logic        isinstruct_WB,
    input  logic [31:0] resume_pc,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        WFI_interrupt
);
    typedef enum logic [1:0] {RUN, WFI, TRAP} state_t;
    localparam logic [3:0] MSTATUS = 4'd0, MTVEC = 4'd1, MIE = 4'd2, MIP = 4'd3, MEPC = 4'd4;
    localparam logic [3:0] INSTRETH = 4'd5, INSTRET = 4'd6, CYCLEH = 4'd7, CYCLE = 4'd8;
`ifdef CSR_TIMER_IRQ_EN
    localparam logic [31:0] MIE_MASK = 32'h0000_0880;
    logic tmr;
    assign tmr = timer_irq;
`else
    localparam logic [31:0] MIE_MASK = 32'h0000_0800;
    logic tmr;
    assign tmr = 1'b0;
`endif
    state_t      state;
    logic        wfi_q, trap_q;
    logic        mstatus_mie, mstatus_mpie;
    logic [29:0] mtvec_q, mepc_q;
    logic [31:0] mie_q;
    logic [63:0] cycle_q, instret_q;
    logic        unused_bits;
    assign unused_bits = ^{funct3_WB[2], timer_irq};

    function automatic logic [31:0] csr_op(input logic [1:0] op, input logic [31:0] old, input logic [31:0] d);
        return op == 2'b01 ? d : op == 2'b10 ? (old | d) : op == 2'b11 ? (old & ~d) : old;
    endfunction

    logic        wr_en, pending, trap, mret, enter_trap;
    logic [31:0] mstatus_cur, mtvec_cur, mepc_cur, mip_cur;
    logic [31:0] mstatus_w, mtvec_w, mie_w, mepc_w;
    assign wr_en       = isCSR_WB & (funct3_WB[1:0] != 2'b00) & ~rst;
    assign mstatus_cur = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mtvec_cur   = {mtvec_q, 2'b00};
    assign mepc_cur    = {mepc_q, 2'b00};
    assign mip_cur     = {20'b0, ext_irq, 3'b0, tmr, 7'b0};
    // post-write values give both the next register contents and the read bypass
    assign mstatus_w = (wr_en && csr_WB == MSTATUS) ? csr_op(funct3_WB[1:0], mstatus_cur, wdata_WB) : mstatus_cur;
    assign mtvec_w   = (wr_en && csr_WB == MTVEC) ? csr_op(funct3_WB[1:0], mtvec_cur, wdata_WB) : mtvec_cur;
    assign mie_w     = ((wr_en && csr_WB == MIE) ? csr_op(funct3_WB[1:0], mie_q, wdata_WB) : mie_q) & MIE_MASK;
    assign mepc_w    = (wr_en && csr_WB == MEPC) ? csr_op(funct3_WB[1:0], mepc_cur, wdata_WB) : mepc_cur;
    assign pending    = |(mie_q & mip_cur);
    assign trap       = pending & mstatus_mie & (state == RUN) & ~isMRET_WB;
    assign mret       = isMRET_WB & (state == RUN) & ~rst;
    assign enter_trap = trap | ((state == WFI) & pending & mstatus_mie);
    assign redirect      = trap_q | mret;
    assign redirect_pc   = trap_q ? mtvec_cur : mepc_cur;
    assign WFI_interrupt = wfi_q;

    // read mux over post-write values so a same-cycle WB write is visible
    always_comb begin
        csr_rdata = 32'b0;
        case (csr_ID)
            MSTATUS:  csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_w[7], 3'b0, mstatus_w[3], 3'b0};
            MTVEC:    csr_rdata = {mtvec_w[31:2], 2'b00};
            MIE:      csr_rdata = mie_w;
            MIP:      csr_rdata = mip_cur;
            MEPC:     csr_rdata = {mepc_w[31:2], 2'b00};
            INSTRETH: csr_rdata = instret_q[63:32];
            INSTRET:  csr_rdata = instret_q[31:0];
            CYCLEH:   csr_rdata = cycle_q[63:32];
            CYCLE:    csr_rdata = cycle_q[31:0];
            default:  csr_rdata = 32'b0;
        endcase
    end

    // control FSM with registered WFI/trap flags, CSR updates (trap/MRET override writes) and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            wfi_q        <= 1'b0;
            trap_q       <= 1'b0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec_q      <= '0;
            mepc_q       <= '0;
            mie_q        <= '0;
            cycle_q      <= '0;
            instret_q    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (trap) begin
                        state  <= TRAP;
                        trap_q <= 1'b1;
                    end else if (isWFI_WB && !pending) begin
                        state <= WFI;
                        wfi_q <= 1'b1;
                    end
                end
                WFI: begin
                    if (pending) begin
                        state  <= mstatus_mie ? TRAP : RUN;
                        trap_q <= mstatus_mie;
                        wfi_q  <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    trap_q <= 1'b0;
                    wfi_q  <= 1'b0;
                end
            endcase
            mtvec_q      <= mtvec_w[31:2];
            mie_q        <= mie_w;
            mepc_q       <= enter_trap ? resume_pc[31:2] : mepc_w[31:2];
            mstatus_mie  <= enter_trap ? 1'b0 : mret ? mstatus_mpie : mstatus_w[3];
            mstatus_mpie <= enter_trap ? mstatus_mie : mret ? 1'b1 : mstatus_w[7];
            cycle_q      <= cycle_q + 64'd1;
            instret_q    <= instret_q + 64'(isinstruct_WB);
        end
    end
endmodule
